img_rom_arbiter: RTL and testbench
==================================

# img_rom_arbiter

Round-robin arbiter that shares one single-port 48x64 image ROM (12-bit address {y[5:0], x[5:0]}, 12-bit RGB444 data, one-cycle registered read) between NREQ pixel-fetch requesters, e.g. the landing-sprite draw pipeline and the collision checker. It grants one requester per cycle, drives a registered ROM address, and returns RGB data to the originating requester with a fixed two-cycle latency. It sits between the game's draw/logic blocks and the `img_rom_*` instances.

## Interface
- `NREQ`, 2, number of requesters (2..4)
- `IMG_W`, 48, image width in pixels; x field values ≥ IMG_W are out of range
- `OOB_RGB`, 12'h000, colour returned for out-of-range requests (masking build only)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  per-requester request strobe; bit i = requester i
- `req_addr`  in  12*NREQ  per-requester address; requester i at [12*i+11:12*i], {y[5:0], x[5:0]}
- `req_ready`  out  NREQ  combinational one-hot grant; a request transfers when valid & ready
- `rom_addr`  out  12  registered address to ROM `address`
- `rom_rgb`  in  12  ROM `rgb` output
- `rsp_valid`  out  NREQ  one-hot, 1-cycle pulse: data for requester i on `rsp_rgb`
- `rsp_rgb`  out  12  returned pixel colour, shared by all requesters
- `busy`  out  1  high while any accepted request has not yet produced its response

## Operation
- Arbitration: round-robin pointer `ptr` (0..NREQ-1). Search order: ptr, ptr+1, … wrapping. First valid requester in that order gets `req_ready`. If none is valid, `req_ready`=0 and `ptr` is unchanged.
- On transfer by requester g: `ptr` ← (g+1) mod NREQ; stage-1 registers capture the address and one-hot tag g.
- `req_ready` depends on `req_valid`. Requesters must not gate `req_valid` on `req_ready`. Requesters hold `req_valid`/`req_addr` stable until the transfer.
- Pipeline:
  - S0: arbitrate.
  - S1: `rom_addr` ← granted address; tag1 ← one-hot g; v1 ← 1.
  - S2: ROM registers `rom_rgb`; tag2 ← tag1, v2 ← v1.
  - Output: `rsp_rgb` = `rom_rgb` (or OOB_RGB, see Configuration); `rsp_valid` = tag2 when v2, else 0.
- Idle cycles: `rom_addr` holds its last value. v1/v2 clear, so no `rsp_valid` pulses.
- No response back-pressure: the requester must consume data in the `rsp_valid` cycle.
- Throughput: one accepted request per cycle sustained. With all NREQ requesters valid, each is granted exactly once every NREQ cycles.
- `busy` = v1 | v2.
- Reset values: `rom_addr`=0, `rsp_valid`=0, `rsp_rgb` select path forced to 0, `ptr`=0, tags=0, v1=v2=0, `busy`=0. `req_ready` is forced to 0 while `rst_n`=0.
- Reset mid-operation: in-flight requests are discarded and no responses are produced for them. The first grant after deassertion goes to the lowest-index valid requester.

## Timing
- Request accepted at rising edge E0. `rom_addr` is valid after E0. ROM data registers at E1. `rsp_valid`/`rsp_rgb` are valid in the cycle after E1 and sampled at E2.
- Latency is exactly 2 clocks from transfer edge to response sample edge, independent of contention.
- Back-to-back transfers at E0 and E1 produce responses sampled at E2 and E3, in grant order.
- `req_ready` is combinational from `req_valid` and `ptr` only. `rom_addr` is a register output.

## Configuration
- `IMG_ROM_OOB_MASK_EN` defined:
  - A request with x field (addr[5:0]) ≥ IMG_W is still granted and consumes its slot.
  - `rom_addr` is not updated for that request.
  - An OOB flag travels with the tag, and the response returns `OOB_RGB` with the same 2-cycle latency.
- `IMG_ROM_OOB_MASK_EN` undefined: the address passes to the ROM unchanged and the response is whatever the ROM returns. No OOB flag register is built.

## Test plan
- Single request: requester 0 addr 12'h041 (y=1, x=1), ROM preloaded with 12'hABC at 0x041. Required: `req_ready[0]` high in the same cycle; `rom_addr`=0x041 after E0; `rsp_valid`=2'b01 with `rsp_rgb`=12'hABC sampled at E2; `busy` high E0–E2 only.
- Contention, NREQ=2: both requesters valid continuously for 6 cycles from reset. Required: grants 0,1,0,1,0,1; responses are one-hot alternating, each with the correct ROM word, with no bubbles.
- Rotation, NREQ=3: requesters 1 and 2 valid with ptr=0. Required: grant 1, then 2, then 1; requester 0 asserting later is granted once ptr reaches 0.
- Streaming: requester 1 issues 64 consecutive addresses y=5, x=0..47 plus 16 further. Required: 64 responses in order, one per cycle, with matching data.
- Out-of-range with the macro defined: addr x=50 (0x032 | y<<6). Required: `rom_addr` unchanged and `rsp_rgb`=OOB_RGB at E2. Without the macro: `rom_addr`=request address and ROM data is returned.
- Reset mid-flight: assert `rst_n`=0 one cycle after a transfer. Required: `rsp_valid`, `busy`, and `rom_addr` go to 0 immediately, and no response appears after release.

Source files
------------

// File: rtl/img_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read image ROM between NREQ pixel fetchers.
// Optional build macro IMG_ROM_OOB_MASK_EN masks out-of-range x requests to OOB_RGB.
module img_rom_arbiter #(
  parameter int          NREQ    = 2,
  parameter int          IMG_W   = 48,
  parameter logic [11:0] OOB_RGB = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [12*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]      req_ready,
  output logic [11:0]          rom_addr,
  input  logic [11:0]          rom_rgb,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [11:0]          rsp_rgb,
  output logic                 busy
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_next;
  logic [PW-1:0]   gidx;
  logic [PW:0]     sum;
  logic [PW:0]     nxt;
  logic            found;
  logic [NREQ-1:0] grant;
  logic [11:0]     sel_addr;
  logic [NREQ-1:0] tag1;
  logic [NREQ-1:0] tag2;
  logic            v1;
  logic            v2;

  // Search from ptr upward with wrap; the first valid requester wins the slot.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    grant    = '0;
    sel_addr = '0;
    sum      = '0;
    nxt      = '0;
    ptr_next = ptr;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (!found && req_valid[sum[PW-1:0]]) begin
        found = 1'b1;
        gidx  = sum[PW-1:0];
      end
    end
    if (!rst_n) found = 1'b0;
    if (found) begin
      grant = NREQ'(1) << gidx;
      for (int k = 0; k < NREQ; k++) begin
        if (PW'(k) == gidx) sel_addr = req_addr[12*k +: 12];
      end
      nxt = {1'b0, gidx} + (PW+1)'(1);
      if (nxt >= (PW+1)'(NREQ)) nxt = nxt - (PW+1)'(NREQ);
      ptr_next = nxt[PW-1:0];
    end
  end

  assign req_ready = grant;

`ifdef IMG_ROM_OOB_MASK_EN
  logic sel_oob;
  logic oob1;
  logic oob2;

  assign sel_oob = ({26'd0, sel_addr[5:0]} >= 32'(IMG_W));

  // The out-of-range flag rides alongside the tag so the masked colour lines up with its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob1 <= 1'b0;
      oob2 <= 1'b0;
    end else begin
      oob1 <= found & sel_oob;
      oob2 <= oob1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      rom_addr <= '0;
      tag1     <= '0;
      tag2     <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
    end else begin
      ptr  <= ptr_next;
      v1   <= found;
      tag1 <= grant;
      v2   <= v1;
      tag2 <= tag1;
`ifdef IMG_ROM_OOB_MASK_EN
      if (found && !sel_oob) rom_addr <= sel_addr;
`else
      if (found) rom_addr <= sel_addr;
`endif
    end
  end

  assign rsp_valid = v2 ? tag2 : '0;
  assign busy      = v1 | v2;

`ifdef IMG_ROM_OOB_MASK_EN
  assign rsp_rgb = !rst_n ? 12'h000 : (oob2 ? OOB_RGB : rom_rgb);
`else
  assign rsp_rgb = !rst_n ? 12'h000 : rom_rgb;
`endif

endmodule

// File: tb/tb_img_rom_arbiter.sv
// Directed bench for img_rom_arbiter: a table-driven NREQ=2 instance plus an NREQ=3
// instance for rotation and streaming, with behavioural registered-read ROMs.
module tb_img_rom_arbiter;

  logic        clk;
  logic        rst_n;

  logic [1:0]  valid2;
  logic [23:0] addr2;
  logic [1:0]  ready2;
  logic [11:0] rom_addr2;
  logic [11:0] rom_rgb2;
  logic [1:0]  rsp_valid2;
  logic [11:0] rsp_rgb2;
  logic        busy2;

  logic [2:0]  valid3;
  logic [35:0] addr3;
  logic [2:0]  ready3;
  logic [11:0] rom_addr3;
  logic [11:0] rom_rgb3;
  logic [2:0]  rsp_valid3;
  logic [11:0] rsp_rgb3;
  logic        busy3;

  int checks = 0;
  int errors = 0;

  img_rom_arbiter #(.NREQ(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid2), .req_addr(addr2), .req_ready(ready2),
    .rom_addr(rom_addr2), .rom_rgb(rom_rgb2), .rsp_valid(rsp_valid2), .rsp_rgb(rsp_rgb2),
    .busy(busy2)
  );

  img_rom_arbiter #(.NREQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_addr(addr3), .req_ready(ready3),
    .rom_addr(rom_addr3), .rom_rgb(rom_rgb3), .rsp_valid(rsp_valid3), .rsp_rgb(rsp_rgb3),
    .busy(busy3)
  );

  function automatic logic [11:0] rom_f(input logic [11:0] a);
    return (a == 12'h041) ? 12'hABC : ~a;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_rgb2 <= rom_f(rom_addr2);
    rom_rgb3 <= rom_f(rom_addr3);
  end

  typedef struct {
    logic [1:0]  valid;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [1:0]  ready;
    logic [11:0] rom_addr;
    logic [1:0]  rsp_valid;
    logic [11:0] rsp_rgb;
    logic        busy;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input int n, input vec_t v);
    check($sformatf("row%0d rom_addr", n), 32'(rom_addr2), 32'(v.rom_addr));
    check($sformatf("row%0d rsp_valid", n), 32'(rsp_valid2), 32'(v.rsp_valid));
    check($sformatf("row%0d busy", n), 32'(busy2), 32'(v.busy));
    if (v.rsp_valid != 2'b00)
      check($sformatf("row%0d rsp_rgb", n), 32'(rsp_rgb2), 32'(v.rsp_rgb));
  endtask

  task automatic apply_stimulus(input int n, input vec_t v);
    valid2 = v.valid;
    addr2  = {v.a1, v.a0};
    #1;
    check($sformatf("row%0d req_ready", n), 32'(ready2), 32'(v.ready));
    tick();
    check_output(n, v);
  endtask

  initial begin
    logic [11:0] sa;
    logic [11:0] exp_q[64];
    int          rsp_count;

    // Contention from reset, drain, single request to 0, single request to 1.
    vecs[0]  = '{2'b11, 12'h041, 12'h0C5, 2'b01, 12'h041, 2'b00, 12'h000, 1'b1};
    vecs[1]  = '{2'b11, 12'h041, 12'h0C5, 2'b10, 12'h0C5, 2'b01, 12'hABC, 1'b1};
    vecs[2]  = '{2'b11, 12'h041, 12'h0C5, 2'b01, 12'h041, 2'b10, 12'hF3A, 1'b1};
    vecs[3]  = '{2'b11, 12'h041, 12'h0C5, 2'b10, 12'h0C5, 2'b01, 12'hABC, 1'b1};
    vecs[4]  = '{2'b11, 12'h041, 12'h0C5, 2'b01, 12'h041, 2'b10, 12'hF3A, 1'b1};
    vecs[5]  = '{2'b11, 12'h041, 12'h0C5, 2'b10, 12'h0C5, 2'b01, 12'hABC, 1'b1};
    vecs[6]  = '{2'b00, 12'h041, 12'h0C5, 2'b00, 12'h0C5, 2'b10, 12'hF3A, 1'b1};
    vecs[7]  = '{2'b00, 12'h041, 12'h0C5, 2'b00, 12'h0C5, 2'b00, 12'h000, 1'b0};
    vecs[8]  = '{2'b01, 12'h041, 12'h0C5, 2'b01, 12'h041, 2'b00, 12'h000, 1'b1};
    vecs[9]  = '{2'b00, 12'h041, 12'h0C5, 2'b00, 12'h041, 2'b01, 12'hABC, 1'b1};
    vecs[10] = '{2'b00, 12'h041, 12'h0C5, 2'b00, 12'h041, 2'b00, 12'h000, 1'b0};
    vecs[11] = '{2'b10, 12'h041, 12'h0C5, 2'b10, 12'h0C5, 2'b00, 12'h000, 1'b1};
    vecs[12] = '{2'b00, 12'h041, 12'h0C5, 2'b00, 12'h0C5, 2'b10, 12'hF3A, 1'b1};
    vecs[13] = '{2'b00, 12'h041, 12'h0C5, 2'b00, 12'h0C5, 2'b00, 12'h000, 1'b0};

    rst_n  = 1'b0;
    valid2 = 2'b11;
    addr2  = {12'h0C5, 12'h041};
    valid3 = 3'b000;
    addr3  = '0;
    #12;
    check("reset req_ready", 32'(ready2), 32'h0);
    check("reset rom_addr", 32'(rom_addr2), 32'h0);
    check("reset rsp_valid", 32'(rsp_valid2), 32'h0);
    check("reset rsp_rgb", 32'(rsp_rgb2), 32'h0);
    check("reset busy", 32'(busy2), 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    valid2 = 2'b00;

    for (int i = 0; i < 14; i++) apply_stimulus(i, vecs[i]);

    // Rotation on the three-requester instance: 1,2,1 then requester 0 once ptr reaches it.
    valid3 = 3'b110;
    addr3  = {12'h202, 12'h101, 12'h303};
    #1;
    check("rot grant1", 32'(ready3), 32'b010);
    tick();
    check("rot rom_addr1", 32'(rom_addr3), 32'h101);
    check("rot grant2", 32'(ready3), 32'b100);
    tick();
    check("rot rom_addr2", 32'(rom_addr3), 32'h202);
    check("rot grant1b", 32'(ready3), 32'b010);
    tick();
    valid3 = 3'b111;
    #1;
    check("rot grant2b", 32'(ready3), 32'b100);
    tick();
    check("rot grant0", 32'(ready3), 32'b001);
    tick();
    check("rot rom_addr0", 32'(rom_addr3), 32'h303);
    valid3 = 3'b000;
    tick();
    tick();
    check("rot idle busy", 32'(busy3), 32'h0);

    // Streaming 64 addresses from requester 1, one response per cycle in order.
    rsp_count = 0;
    valid3 = 3'b010;
    for (int i = 0; i < 64; i++) begin
      sa = (i < 48) ? {6'd5, 6'(i)} : {6'd6, 6'(i - 48)};
      addr3[23:12] = sa;
      exp_q[i] = rom_f(sa);
      #1;
      check($sformatf("stream ready %0d", i), 32'(ready3), 32'b010);
      tick();
      if (i >= 1) begin
        check($sformatf("stream rsp_valid %0d", i - 1), 32'(rsp_valid3), 32'b010);
        check($sformatf("stream rsp_rgb %0d", i - 1), 32'(rsp_rgb3), 32'(exp_q[i-1]));
      end
      if (rsp_valid3 == 3'b010) rsp_count++;
    end
    valid3 = 3'b000;
    tick();
    check("stream rsp_valid 63", 32'(rsp_valid3), 32'b010);
    check("stream rsp_rgb 63", 32'(rsp_rgb3), 32'(exp_q[63]));
    if (rsp_valid3 == 3'b010) rsp_count++;
    tick();
    check("stream tail quiet", 32'(rsp_valid3), 32'h0);
    check("stream count", 32'(rsp_count), 32'd64);

    // Out-of-range x=50 on requester 0 (ptr is back at 0 after the table).
    valid2 = 2'b01;
    addr2  = {12'h0C5, 12'h0B2};
    #1;
    check("oob ready", 32'(ready2), 32'b01);
    tick();
`ifdef IMG_ROM_OOB_MASK_EN
    check("oob rom_addr", 32'(rom_addr2), 32'h0C5);
`else
    check("oob rom_addr", 32'(rom_addr2), 32'h0B2);
`endif
    valid2 = 2'b00;
    tick();
    check("oob rsp_valid", 32'(rsp_valid2), 32'b01);
`ifdef IMG_ROM_OOB_MASK_EN
    check("oob rsp_rgb", 32'(rsp_rgb2), 32'h000);
`else
    check("oob rsp_rgb", 32'(rsp_rgb2), 32'hF4D);
`endif
    tick();

    // Reset while a response is in flight: everything drops at once and nothing leaks out.
    valid2 = 2'b10;
    addr2  = {12'h0C5, 12'h041};
    tick();
    valid2 = 2'b00;
    tick();
    check("mid pre rsp_valid", 32'(rsp_valid2), 32'b10);
    rst_n  = 1'b0;
    valid2 = 2'b11;
    #1;
    check("mid rsp_valid", 32'(rsp_valid2), 32'h0);
    check("mid busy", 32'(busy2), 32'h0);
    check("mid rom_addr", 32'(rom_addr2), 32'h0);
    check("mid req_ready", 32'(ready2), 32'h0);
    tick();
    rst_n  = 1'b1;
    valid2 = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post rsp_valid %0d", i), 32'(rsp_valid2), 32'h0);
      check($sformatf("post busy %0d", i), 32'(busy2), 32'h0);
    end
    valid2 = 2'b11;
    #1;
    check("post first grant", 32'(ready2), 32'b01);
    valid2 = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
